// File: rtl/ledscan_pkg.sv
// ledscan_pkg: shared types and constants for the HUB75 BCM scan scheduler.
// Contents: scan FSM state encoding, default parameter values and the
// row-change deghost delay used when LEDSCAN_SCHED_DEGHOST_EN is defined.
package ledscan_pkg;

    // Scan sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2,
        LATCH = 2'd3
    } state_t;

    // Default geometry: 128 columns, 32 row pairs, 8 bitplanes, 16-clock LSB.
    localparam int DEF_X_BITS     = 7;
    localparam int DEF_Y_BITS     = 5;
    localparam int DEF_PLANES     = 8;
    localparam int DEF_BASE_SHIFT = 4;

    // Blanked settling cycles inserted after a row change (plane-0 latch).
    localparam logic [1:0] DEGHOST_DLY = 2'd2;

    // True when the plane being latched starts a new row.
    function automatic logic is_row_change(input logic [2:0] plane);
        return (plane == 3'd0);
    endfunction

endpackage

// File: rtl/ledscan_bcm_timer.sv
// ledscan_bcm_timer: per-plane display period / on-time counter.
// On load, captures period P = 1 << (BASE_SHIFT+plane) and on-time
// ON = (brightness << (BASE_SHIFT+plane)) >> 8, waits 'delay' blanked cycles,
// then counts 0..P-1 with blank_n high while count < ON.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   enable          : low clears the timer (aborts a display)
//   load            : start a new plane display (held for one cycle)
//   plane           : plane index being latched
//   brightness      : global on-time fraction n/256, sampled with load
//   delay           : blanked cycles before counting starts
//   blank_n         : registered, high while LEDs may be lit
//   done            : timer idle or at its final count
module ledscan_bcm_timer
    import ledscan_pkg::*;
#(
    parameter int BASE_SHIFT = DEF_BASE_SHIFT,
    parameter int PLANES     = DEF_PLANES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [2:0] plane,
    input  logic [7:0] brightness,
    input  logic [1:0] delay,
    output logic       blank_n,
    output logic       done
);

    localparam int CW = BASE_SHIFT + PLANES;

    logic [CW+7:0] on_wide_s;
    logic [CW-1:0] on_s;
    logic [CW-1:0] pmax_s;
    logic [CW-1:0] cnt_inc_s;

    logic          active_r;
    logic [1:0]    dly_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] on_r;
    logic [CW-1:0] pmax_r;
    logic          blank_n_r;

    // Shift-only on-time and period computation for the plane being loaded.
    always_comb begin
        on_wide_s = {{CW{1'b0}}, brightness} << (BASE_SHIFT + int'(plane));
        on_s      = on_wide_s[CW+7:8];
        pmax_s    = (CW'(1) << (BASE_SHIFT + int'(plane))) - CW'(1);
        cnt_inc_s = cnt_r + CW'(1);
    end

    // Counter, delay and lit-window register; blank_n tracks the next count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_r  <= 1'b0;
            dly_r     <= 2'd0;
            cnt_r     <= {CW{1'b0}};
            on_r      <= {CW{1'b0}};
            pmax_r    <= {CW{1'b0}};
            blank_n_r <= 1'b0;
        end else if (!enable) begin
            active_r  <= 1'b0;
            dly_r     <= 2'd0;
            cnt_r     <= {CW{1'b0}};
            on_r      <= {CW{1'b0}};
            pmax_r    <= {CW{1'b0}};
            blank_n_r <= 1'b0;
        end else if (load) begin
            active_r  <= 1'b1;
            dly_r     <= delay;
            cnt_r     <= {CW{1'b0}};
            on_r      <= on_s;
            pmax_r    <= pmax_s;
            blank_n_r <= (delay == 2'd0) && (on_s != {CW{1'b0}});
        end else if (active_r) begin
            if (dly_r != 2'd0) begin
                // Count stays at 0 while settling; light up as the delay expires.
                dly_r     <= dly_r - 2'd1;
                blank_n_r <= (dly_r == 2'd1) && (on_r != {CW{1'b0}});
            end else if (cnt_r == pmax_r) begin
                active_r  <= 1'b0;
                blank_n_r <= 1'b0;
            end else begin
                cnt_r     <= cnt_inc_s;
                blank_n_r <= (cnt_inc_s < on_r);
            end
        end else begin
            blank_n_r <= 1'b0;
        end
    end

    // Done when idle or on the last count of an undelayed period.
    always_comb begin
        if (!active_r) begin
            done = 1'b1;
        end else begin
            done = (dly_r == 2'd0) && (cnt_r == pmax_r);
        end
    end

    assign blank_n = blank_n_r;

endmodule

// File: rtl/ledscan_sched.sv
// ledscan_sched: HUB75 binary-coded-modulation scan scheduler.
// Shifts the columns of the next bitplane while the current plane is
// displayed, then latches, updates the displayed row and restarts the
// display timer for the latched plane.
// Optional feature: define LEDSCAN_SCHED_DEGHOST_EN to hold blank for two
// extra cycles after every row change (plane-0 latch) before the timer runs.
// Ports:
//   clk, reset   : pixel clock, asynchronous active-high reset
//   enable       : run the scan; low returns to idle and aborts the display
//   brightness   : global on-time fraction n/256
//   addrx        : column being shifted
//   shift_row    : row whose data is being shifted
//   shift_plane  : plane being shifted
//   shift_en     : column valid (SCLK gate)
//   latch        : panel latch strobe
//   blank        : panel OE, active-high blank
//   addry        : row currently displayed
//   frame_start  : pulse with the latch of row 0, plane 0
module ledscan_sched
    import ledscan_pkg::*;
#(
    parameter int X_BITS     = DEF_X_BITS,
    parameter int Y_BITS     = DEF_Y_BITS,
    parameter int PLANES     = DEF_PLANES,
    parameter int BASE_SHIFT = DEF_BASE_SHIFT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [7:0]        brightness,
    output logic [X_BITS-1:0] addrx,
    output logic [Y_BITS-1:0] shift_row,
    output logic [2:0]        shift_plane,
    output logic              shift_en,
    output logic              latch,
    output logic              blank,
    output logic [Y_BITS-1:0] addry,
    output logic              frame_start
);

    localparam logic [X_BITS-1:0] ADDRX_MAX  = {X_BITS{1'b1}};
    localparam logic [2:0]        PLANE_LAST = 3'(PLANES - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [X_BITS-1:0] addrx_r;
    logic [Y_BITS-1:0] shift_row_r;
    logic [2:0]        shift_plane_r;
    logic              shift_en_r;
    logic              latch_r;
    logic [Y_BITS-1:0] addry_r;
    logic              frame_start_r;
    logic              timer_load_s;
    logic [1:0]        timer_dly_s;
    logic              timer_blank_n_s;
    logic              timer_done_s;

    // Next-state logic for the shift / wait / latch sequence.
    always_comb begin
        state_nxt_s = state_r;
        if (!enable) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE:  state_nxt_s = SHIFT;
                SHIFT: begin
                    if (addrx_r == ADDRX_MAX) begin
                        state_nxt_s = timer_done_s ? LATCH : WAIT;
                    end else begin
                        state_nxt_s = SHIFT;
                    end
                end
                WAIT:  state_nxt_s = timer_done_s ? LATCH : WAIT;
                LATCH: state_nxt_s = SHIFT;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Timer load strobe and, optionally, the row-change settling delay.
    always_comb begin
        timer_load_s = 1'b0;
        timer_dly_s  = 2'd0;
        if (state_r == LATCH) begin
            timer_load_s = 1'b1;
`ifdef LEDSCAN_SCHED_DEGHOST_EN
            if (is_row_change(shift_plane_r)) begin
                timer_dly_s = DEGHOST_DLY;
            end else begin
                timer_dly_s = 2'd0;
            end
`endif
        end else begin
            timer_load_s = 1'b0;
        end
    end

    // State, shift indexes and strobes; strobes are decoded from the next state
    // so they are valid in the same cycle as the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            addrx_r       <= {X_BITS{1'b0}};
            shift_row_r   <= {Y_BITS{1'b0}};
            shift_plane_r <= 3'd0;
            shift_en_r    <= 1'b0;
            latch_r       <= 1'b0;
            addry_r       <= {Y_BITS{1'b0}};
            frame_start_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            shift_en_r    <= (state_nxt_s == SHIFT);
            latch_r       <= (state_nxt_s == LATCH);
            frame_start_r <= (state_nxt_s == LATCH) &&
                             (shift_row_r == {Y_BITS{1'b0}}) &&
                             (shift_plane_r == 3'd0);
            if (!enable) begin
                addrx_r       <= {X_BITS{1'b0}};
                shift_row_r   <= {Y_BITS{1'b0}};
                shift_plane_r <= 3'd0;
                addry_r       <= {Y_BITS{1'b0}};
            end else begin
                case (state_r)
                    SHIFT: addrx_r <= addrx_r + X_BITS'(1);
                    LATCH: begin
                        addrx_r <= {X_BITS{1'b0}};
                        addry_r <= shift_row_r;
                        if (shift_plane_r == PLANE_LAST) begin
                            shift_plane_r <= 3'd0;
                            shift_row_r   <= shift_row_r + Y_BITS'(1);
                        end else begin
                            shift_plane_r <= shift_plane_r + 3'd1;
                        end
                    end
                    default: addrx_r <= addrx_r;
                endcase
            end
        end
    end

    ledscan_bcm_timer #(
        .BASE_SHIFT (BASE_SHIFT),
        .PLANES     (PLANES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (timer_load_s),
        .plane      (shift_plane_r),
        .brightness (brightness),
        .delay      (timer_dly_s),
        .blank_n    (timer_blank_n_s),
        .done       (timer_done_s)
    );

    assign addrx       = addrx_r;
    assign shift_row   = shift_row_r;
    assign shift_plane = shift_plane_r;
    assign shift_en    = shift_en_r;
    assign latch       = latch_r;
    // Direct inversion of the timer's flop: blank resets high and stays high
    // whenever the timer is idle, delayed or past its on-time.
    assign blank       = ~timer_blank_n_s;
    assign addry       = addry_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_ledscan_sched.sv
// Self-checking bench for ledscan_sched using a reduced geometry
// (16 columns, 4 rows, 8 planes, BASE_SHIFT 2) so that whole frames fit in
// a short run. Slot lengths: planes 0-2 -> 17, then 33, 65, 129, 257, 513;
// one row = 1048 clocks, one frame = 4192 clocks.
module tb_ledscan_sched;
    localparam int XB = 4, YB = 2, PL = 8, BS = 2;
    localparam int NCOL = 1 << XB;
    localparam int FRAME_CYC = 4192;
`ifdef LEDSCAN_SCHED_DEGHOST_EN
    localparam int DG = 2;
`else
    localparam int DG = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic [7:0] brightness = 8'd0;
    logic [XB-1:0] addrx;
    logic [YB-1:0] shift_row, addry;
    logic [2:0] shift_plane;
    logic shift_en, latch, blank, frame_start;

    ledscan_sched #(.X_BITS(XB), .Y_BITS(YB), .PLANES(PL), .BASE_SHIFT(BS)) dut (
        .clk(clk), .reset(reset), .enable(enable), .brightness(brightness),
        .addrx(addrx), .shift_row(shift_row), .shift_plane(shift_plane),
        .shift_en(shift_en), .latch(latch), .blank(blank), .addry(addry),
        .frame_start(frame_start));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int row; int plane; bit fs; int gap; int low; int first;} exp_t;
    exp_t sbq[$];
    int checks = 0, failures = 0;
    int m_row, m_plane, m_prev_plane, m_prev_b;
    bit m_first = 1'b1;
    bit have_prev = 1'b0, have_fs = 1'b0;
    int last_row = 0, last_fs_cyc = 0, last_plane = 0;

    function automatic int on_time(input int p, input int b);
        return (b << (BS + p)) >> 8;
    endfunction

    task automatic model_restart();
        m_row = 0; m_plane = 0; m_first = 1'b1; have_prev = 1'b0; have_fs = 1'b0;
    endtask

    // Expected next latch: its indexes plus the slot that precedes it.
    task automatic push_one(input int b);
        exp_t e;
        int d, p;
        e.row = m_row; e.plane = m_plane; e.fs = (m_row == 0 && m_plane == 0);
        if (m_first) begin
            e.gap = NCOL + 1; e.low = 0; e.first = 0;
        end else begin
            d = (m_prev_plane == 0) ? DG : 0;
            p = (1 << (BS + m_prev_plane)) + d;
            e.gap = ((p > NCOL) ? p : NCOL) + 1;
            e.low = on_time(m_prev_plane, m_prev_b);
            e.first = 1 + d;
        end
        sbq.push_back(e);
        m_prev_plane = m_plane; m_prev_b = b; m_first = 1'b0;
        if (m_plane == PL - 1) begin
            m_plane = 0; m_row = (m_row + 1) % (1 << YB);
        end else begin
            m_plane = m_plane + 1;
        end
    endtask

    // Runs n latches with the given brightness (applied from the current cycle).
    task automatic run_latches(input int n, input int b);
        exp_t e;
        int gap, low, first, last;
        bit got, bad_fs, bad_shift, bad_addry;
        brightness = 8'(b);
        if (!m_first) m_prev_b = b;
        for (int i = 0; i < n; i++) begin
            push_one(b);
            gap = 0; low = 0; first = 0; last = 0;
            got = 0; bad_fs = 0; bad_shift = 0; bad_addry = 0;
            for (int c = 0; c < 2000 && !got; c++) begin
                @(posedge clk); #1;
                gap++;
                if (gap == 1 && have_prev && addry !== YB'(last_row)) bad_addry = 1;
                if (latch === 1'b1) begin
                    got = 1;
                end else begin
                    if (frame_start !== 1'b0) bad_fs = 1;
                    if (gap <= NCOL) begin
                        if (shift_en !== 1'b1 || addrx !== XB'(gap - 1)) bad_shift = 1;
                    end else if (shift_en !== 1'b0) begin
                        bad_shift = 1;
                    end
                    if (blank === 1'b0) begin
                        low++; if (first == 0) first = gap; last = gap;
                    end
                end
            end
            e = sbq.pop_front();
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL latch_timeout: no latch within %0d cycles, required row %0d plane %0d", gap, e.row, e.plane);
                return;
            end
            checks++;
            if (gap != e.gap) begin failures++; $display("FAIL slot_len r%0d p%0d: got %0d required %0d", e.row, e.plane, gap, e.gap); end
            checks++;
            if (low != e.low) begin failures++; $display("FAIL blank_low r%0d p%0d: got %0d required %0d", e.row, e.plane, low, e.low); end
            if (e.low > 0) begin
                checks++;
                if (first != e.first || last != e.first + e.low - 1) begin
                    failures++;
                    $display("FAIL blank_window r%0d p%0d: got %0d..%0d required %0d..%0d", e.row, e.plane, first, last, e.first, e.first + e.low - 1);
                end
            end
            checks++;
            if (shift_row !== YB'(e.row) || shift_plane !== 3'(e.plane)) begin
                failures++; $display("FAIL latch_index: got r%0d p%0d required r%0d p%0d", shift_row, shift_plane, e.row, e.plane);
            end
            checks++;
            if (frame_start !== e.fs) begin failures++; $display("FAIL frame_start r%0d p%0d: got %b required %b", e.row, e.plane, frame_start, e.fs); end
            checks++;
            if (blank !== 1'b1) begin failures++; $display("FAIL blank_at_latch: got %b required 1", blank); end
            checks++;
            if (bad_fs || bad_shift || bad_addry) begin
                failures++; $display("FAIL slot_signals r%0d p%0d: stray_fs=%b shift_seq_err=%b addry_err=%b required all 0", e.row, e.plane, bad_fs, bad_shift, bad_addry);
            end
            if (e.fs) begin
                if (have_fs) begin
                    checks++;
                    if (cyc - last_fs_cyc != FRAME_CYC) begin failures++; $display("FAIL frame_period: got %0d required %0d", cyc - last_fs_cyc, FRAME_CYC); end
                end
                have_fs = 1'b1; last_fs_cyc = cyc;
            end
            have_prev = 1'b1; last_row = e.row; last_plane = e.plane;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; brightness = 8'd0;
        repeat (3) @(posedge clk); #1;
        checks++; if (addrx !== '0 || shift_row !== '0 || shift_plane !== 3'd0 || addry !== '0) begin failures++; $display("FAIL reset_index: addrx=%0d row=%0d plane=%0d addry=%0d required 0", addrx, shift_row, shift_plane, addry); end
        checks++; if (shift_en !== 1'b0 || latch !== 1'b0 || frame_start !== 1'b0) begin failures++; $display("FAIL reset_strobes: shift_en=%b latch=%b fs=%b required 0", shift_en, latch, frame_start); end
        checks++; if (blank !== 1'b1) begin failures++; $display("FAIL reset_blank: got %b required 1", blank); end
        reset = 1'b0;
        repeat (4) @(posedge clk); #1;
        checks++; if (shift_en !== 1'b0 || blank !== 1'b1) begin failures++; $display("FAIL idle_hold: shift_en=%b blank=%b required 0/1", shift_en, blank); end
    endtask

    task automatic test_first_shift();
        model_restart();
        @(posedge clk); #1;
        enable = 1'b1;
        run_latches(1, 128);
        checks++; if (addry !== '0) begin failures++; $display("FAIL first_addry: got %0d required 0", addry); end
    endtask

    task automatic test_full_frame();
        run_latches(32, 128);
    endtask

    task automatic test_brightness_zero();
        run_latches(32, 0);
    endtask

    task automatic test_brightness_full();
        run_latches(8, 255);
    endtask

    task automatic test_enable_abort();
        run_latches(6, 128);
        checks++; if (last_plane != 6) begin failures++; $display("FAIL abort_setup: last plane %0d required 6", last_plane); end
        repeat (40) @(posedge clk); #1;
        checks++; if (blank !== 1'b0 || shift_en !== 1'b0) begin failures++; $display("FAIL pre_abort_wait: blank=%b shift_en=%b required 0/0", blank, shift_en); end
        enable = 1'b0;
        @(posedge clk); #1;
        checks++; if (blank !== 1'b1 || shift_en !== 1'b0 || latch !== 1'b0) begin failures++; $display("FAIL abort_strobes: blank=%b shift_en=%b latch=%b required 1/0/0", blank, shift_en, latch); end
        checks++; if (addrx !== '0 || shift_row !== '0 || shift_plane !== 3'd0) begin failures++; $display("FAIL abort_index: addrx=%0d row=%0d plane=%0d required 0", addrx, shift_row, shift_plane); end
        repeat (5) @(posedge clk); #1;
        checks++; if (blank !== 1'b1 || shift_en !== 1'b0) begin failures++; $display("FAIL abort_idle: blank=%b shift_en=%b required 1/0", blank, shift_en); end
        model_restart();
        enable = 1'b1;
        run_latches(3, 128);
    endtask

    task automatic test_async_reset();
        repeat (5) @(posedge clk); #1;
        checks++; if (shift_en !== 1'b1 || addrx !== XB'(4)) begin failures++; $display("FAIL pre_reset_shift: shift_en=%b addrx=%0d required 1/4", shift_en, addrx); end
        #2 reset = 1'b1;
        #1;
        checks++; if (addrx !== '0 || shift_row !== '0 || shift_plane !== 3'd0 || addry !== '0) begin failures++; $display("FAIL async_reset_index: addrx=%0d row=%0d plane=%0d addry=%0d required 0", addrx, shift_row, shift_plane, addry); end
        checks++; if (shift_en !== 1'b0 || latch !== 1'b0 || frame_start !== 1'b0 || blank !== 1'b1) begin failures++; $display("FAIL async_reset_strobes: shift_en=%b latch=%b fs=%b blank=%b required 0/0/0/1", shift_en, latch, frame_start, blank); end
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_first_shift();
        test_full_frame();
        test_brightness_zero();
        test_brightness_full();
        test_enable_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound in case a task stalls outside its own cycle budgets.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
